lstm_cell_update: RTL and testbench

- Consumes the four gate pre-activations (input i, forget f, output o, candidate g) produced by the concat-multiply-add gate stage.
- Applies hard-sigmoid to i, f and o, and hard-tanh to g.
- Updates the cell state c = f*c_prev + i*g and produces h = o*tanh(c).
- Holds c internally across timesteps and sits directly downstream of the gate stage, with a valid/ready handshake on both sides.

---
 rtl/lstm_cell_update.sv | 218 +++++++++++++++++++++
 tb/tb_lstm_cell_update.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lstm_cell_update.sv
// LSTM cell update: hard-sigmoid/hard-tanh activations, c = f*c_prev + i*g, h = o*tanh(c).
// Optional macro LSTM_CELL_SAT_EN: saturating reductions plus a sticky sat_flag output.
module lstm_cell_update #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] i_pre,
  input  logic [DATA_WIDTH-1:0] f_pre,
  input  logic [DATA_WIDTH-1:0] o_pre,
  input  logic [DATA_WIDTH-1:0] g_pre,
  input  logic                  clear_state,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] h_out,
  output logic [DATA_WIDTH-1:0] c_out
`ifdef LSTM_CELL_SAT_EN
  ,
  output logic                  sat_flag
`endif
);
  localparam int W  = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;

  localparam logic signed [W:0]    ONE_X     = (W+1)'(1) << FRACT_WIDTH;
  localparam logic signed [W:0]    HALF_X    = (W+1)'(1) << (FRACT_WIDTH - 1);
  localparam logic signed [W-1:0]  ONE_W     = W'(1) << FRACT_WIDTH;
  localparam logic signed [W-1:0]  NEG_ONE_W = -ONE_W;
  localparam logic signed [PW-1:0] RED_MAX   = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] RED_MIN   = ~RED_MAX;
  localparam logic [W-1:0]         SAT_MAX_W = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]         SAT_MIN_W = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ACT  = 3'd1,
    S_MUL  = 3'd2,
    S_ADD  = 3'd3,
    S_HOUT = 3'd4,
    S_OUT  = 3'd5
  } state_t;

  function automatic logic signed [W-1:0] hard_sig(input logic signed [W-1:0] x);
    logic signed [W:0] t;
    t = ($signed({x[W-1], x}) >>> 2) + HALF_X;
    if (t < 0)          hard_sig = '0;
    else if (t > ONE_X) hard_sig = ONE_W;
    else                hard_sig = t[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] hard_tanh(input logic signed [W-1:0] x);
    if (x < NEG_ONE_W)  hard_tanh = NEG_ONE_W;
    else if (x > ONE_W) hard_tanh = ONE_W;
    else                hard_tanh = x;
  endfunction

  // Returns {out_of_range, reduced value}; the range bit is the saturation event.
  function automatic logic [W:0] reduce(input logic signed [PW-1:0] x);
    logic hi;
    logic lo;
    hi = (x > RED_MAX);
    lo = (x < RED_MIN);
`ifdef LSTM_CELL_SAT_EN
    if (hi)      reduce = {1'b1, SAT_MAX_W};
    else if (lo) reduce = {1'b1, SAT_MIN_W};
    else         reduce = {1'b0, x[W-1:0]};
`else
    reduce = {hi | lo, x[W-1:0]};
`endif
  endfunction

  state_t state_q, state_d;
  logic signed [W-1:0] i_pre_q, i_pre_d, f_pre_q, f_pre_d;
  logic signed [W-1:0] o_pre_q, o_pre_d, g_pre_q, g_pre_d;
  logic signed [W-1:0] i_act_q, i_act_d, f_act_q, f_act_d;
  logic signed [W-1:0] o_act_q, o_act_d, g_act_q, g_act_d;
  logic signed [W-1:0] pf_q, pf_d, pi_q, pi_d;
  logic signed [W-1:0] c_q, c_d, h_q, h_d;
`ifdef LSTM_CELL_SAT_EN
  logic sat_q, sat_d;
`endif

  logic signed [PW-1:0] prod_f, prod_i, sum_c, prod_h, h_full;
  logic signed [W-1:0]  tanh_c;
  logic [W:0]           red_f, red_i, red_c;
  logic                 unused_bits;

  always_comb begin
    prod_f = PW'(f_act_q) * PW'(c_q);
    prod_i = PW'(i_act_q) * PW'(g_act_q);
    red_f  = reduce(prod_f >>> FRACT_WIDTH);
    red_i  = reduce(prod_i >>> FRACT_WIDTH);
    sum_c  = PW'(pf_q) + PW'(pi_q);
    red_c  = reduce(sum_c);
    tanh_c = hard_tanh(c_q);
    prod_h = PW'(o_act_q) * PW'(tanh_c);
    h_full = prod_h >>> FRACT_WIDTH;
  end

  // Upper bits of h are pure sign extension (both factors lie in [-1, 1]).
  assign unused_bits = ^{h_full[PW-1:W], red_f[W], red_i[W], red_c[W]};

  always_comb begin
    state_d = state_q;
    i_pre_d = i_pre_q;
    f_pre_d = f_pre_q;
    o_pre_d = o_pre_q;
    g_pre_d = g_pre_q;
    i_act_d = i_act_q;
    f_act_d = f_act_q;
    o_act_d = o_act_q;
    g_act_d = g_act_q;
    pf_d    = pf_q;
    pi_d    = pi_q;
    c_d     = c_q;
    h_d     = h_q;
`ifdef LSTM_CELL_SAT_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (clear_state) begin
          c_d = '0;
`ifdef LSTM_CELL_SAT_EN
          sat_d = 1'b0;
`endif
        end
        if (in_valid) begin
          i_pre_d = i_pre;
          f_pre_d = f_pre;
          o_pre_d = o_pre;
          g_pre_d = g_pre;
          state_d = S_ACT;
        end
      end
      S_ACT: begin
        i_act_d = hard_sig(i_pre_q);
        f_act_d = hard_sig(f_pre_q);
        o_act_d = hard_sig(o_pre_q);
        g_act_d = hard_tanh(g_pre_q);
        state_d = S_MUL;
      end
      S_MUL: begin
        pf_d    = red_f[W-1:0];
        pi_d    = red_i[W-1:0];
`ifdef LSTM_CELL_SAT_EN
        sat_d   = sat_q | red_f[W] | red_i[W];
`endif
        state_d = S_ADD;
      end
      S_ADD: begin
        c_d     = red_c[W-1:0];
`ifdef LSTM_CELL_SAT_EN
        sat_d   = sat_q | red_c[W];
`endif
        state_d = S_HOUT;
      end
      S_HOUT: begin
        h_d     = h_full[W-1:0];
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_pre_q <= '0;
      f_pre_q <= '0;
      o_pre_q <= '0;
      g_pre_q <= '0;
      i_act_q <= '0;
      f_act_q <= '0;
      o_act_q <= '0;
      g_act_q <= '0;
      pf_q    <= '0;
      pi_q    <= '0;
      c_q     <= '0;
      h_q     <= '0;
`ifdef LSTM_CELL_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      i_pre_q <= i_pre_d;
      f_pre_q <= f_pre_d;
      o_pre_q <= o_pre_d;
      g_pre_q <= g_pre_d;
      i_act_q <= i_act_d;
      f_act_q <= f_act_d;
      o_act_q <= o_act_d;
      g_act_q <= g_act_d;
      pf_q    <= pf_d;
      pi_q    <= pi_d;
      c_q     <= c_d;
      h_q     <= h_d;
`ifdef LSTM_CELL_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign h_out     = h_q;
  assign c_out     = c_q;
`ifdef LSTM_CELL_SAT_EN
  assign sat_flag  = sat_q;
`endif

endmodule

// File: tb/tb_lstm_cell_update.sv
// Bench for lstm_cell_update: vector table, handshake corner cases and a random run
// against an integer-arithmetic reference model.
module tb_lstm_cell_update;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, clear_state, out_valid, out_ready;
  logic [W-1:0] i_pre, f_pre, o_pre, g_pre, h_out, c_out;
`ifdef LSTM_CELL_SAT_EN
  logic         sat_flag;
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int m_c      = 0;
  bit m_sat    = 1'b0;

  always #5 clk = ~clk;

  lstm_cell_update #(.DATA_WIDTH(16), .FRACT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .i_pre(i_pre), .f_pre(f_pre), .o_pre(o_pre), .g_pre(g_pre),
    .clear_state(clear_state), .out_valid(out_valid), .out_ready(out_ready),
    .h_out(h_out), .c_out(c_out)
`ifdef LSTM_CELL_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model (plain integer arithmetic) ----------------
  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int clampi(input int x, input int lo, input int hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  function automatic int sig_m(input int x);
    return clampi((x >>> 2) + 128, 0, 256);
  endfunction

  function automatic int tanh_m(input int x);
    return clampi(x, -256, 256);
  endfunction

  function automatic int red_m(input int x, inout bit s);
    logic [W-1:0] lo16;
    if (SAT) begin
      if (x > 32767 || x < -32768) s = 1'b1;
      return clampi(x, -32768, 32767);
    end
    lo16 = x[W-1:0];
    return sx(lo16);
  endfunction

  function automatic void model_step(input logic [W-1:0] i, f, o, g, input bit clr,
                                     output logic [W-1:0] eh, output logic [W-1:0] ec);
    int ia, fa, oa, ga, pf, pi, h;
    if (clr) begin
      m_c   = 0;
      m_sat = 1'b0;
    end
    ia  = sig_m(sx(i));
    fa  = sig_m(sx(f));
    oa  = sig_m(sx(o));
    ga  = tanh_m(sx(g));
    pf  = red_m((fa * m_c) >>> 8, m_sat);
    pi  = red_m((ia * ga) >>> 8, m_sat);
    m_c = red_m(pf + pi, m_sat);
    h   = (oa * tanh_m(m_c)) >>> 8;
    eh  = h[W-1:0];
    ec  = m_c[W-1:0];
  endfunction

  // ---------------- handshake helpers ----------------
  task automatic drive(input logic [W-1:0] i, f, o, g, input bit clr);
    int k;
    i_pre = i; f_pre = f; o_pre = o; g_pre = g;
    clear_state = clr;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1; k++;
    end
    if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    clear_state = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 20);
  endtask

  task automatic run_bundle(input logic [W-1:0] i, f, o, g, input bit clr, input int stall,
                            output logic [W-1:0] h, output logic [W-1:0] c);
    int lat;
    out_ready = (stall == 0);
    drive(i, f, o, g, clr);
    wait_out(lat);
    check("latency", lat, 4);
    h = h_out;
    c = c_out;
`ifdef LSTM_CELL_SAT_EN
    check("sat_flag", {31'd0, sat_flag}, {31'd0, m_sat});
`endif
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_h", h_out, h);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [W-1:0] i, f, o, g;
    bit           clr;
    logic [W-1:0] h, c;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [W-1:0] h, c, eh, ec, hold_h, hold_c, ri, rf, ro, rg;
    int lat;

    tbl[0] = '{16'h0800, 16'h0800, 16'h0800, 16'h0080, 1'b0, 16'h0080, 16'h0080};
    tbl[1] = '{16'h0800, 16'h0800, 16'h0800, 16'h0080, 1'b0, 16'h0100, 16'h0100};
    tbl[2] = '{16'h0800, 16'h0800, 16'h0800, 16'h0080, 1'b0, 16'h0100, 16'h0180};
    tbl[3] = '{16'h0000, 16'hF800, 16'h0000, 16'h0100, 1'b0, 16'h0040, 16'h0080};
    tbl[4] = '{16'h0800, 16'h0800, 16'h0800, 16'h0080, 1'b0, 16'h0100, 16'h0100};
    tbl[5] = '{16'h0800, 16'h0800, 16'h0800, 16'h0080, 1'b0, 16'h0100, 16'h0180};
    tbl[6] = '{16'h0800, 16'h0800, 16'h0800, 16'h0080, 1'b1, 16'h0080, 16'h0080};

    rst = 1'b1; in_valid = 1'b0; clear_state = 1'b0; out_ready = 1'b1;
    i_pre = '0; f_pre = '0; o_pre = '0; g_pre = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_h", h_out, 16'h0000);
    check("rst_c", c_out, 16'h0000);

    // Directed vector table
    for (int v = 0; v < 7; v++) begin
      run_bundle(tbl[v].i, tbl[v].f, tbl[v].o, tbl[v].g, tbl[v].clr, 0, h, c);
      model_step(tbl[v].i, tbl[v].f, tbl[v].o, tbl[v].g, tbl[v].clr, eh, ec);
      check($sformatf("tbl%0d_h", v), h, tbl[v].h);
      check($sformatf("tbl%0d_c", v), c, tbl[v].c);
      $display("vec %0d: h=%h c=%h", v, h, c);
    end
    check("drop_out_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: held OUT ignores a pending bundle until transfer
    out_ready = 1'b0;
    drive(16'h0800, 16'h0800, 16'h0800, 16'h0080, 1'b0);
    model_step(16'h0800, 16'h0800, 16'h0800, 16'h0080, 1'b0, eh, ec);
    wait_out(lat);
    check("bp_latency", lat, 4);
    check("bp_h", h_out, eh);
    check("bp_c", c_out, ec);
    hold_h = h_out;
    hold_c = c_out;
    i_pre = 16'h0000; f_pre = 16'h0000; o_pre = 16'h0000; g_pre = 16'h0100;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_hold_h", h_out, hold_h);
      check("bp_hold_c", c_out, hold_c);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_drop", {31'd0, out_valid}, 32'd0);
    check("bp_idle_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_step(16'h0000, 16'h0000, 16'h0000, 16'h0100, 1'b0, eh, ec);
    wait_out(lat);
    check("bp2_latency", lat, 4);
    check("bp2_h", h_out, eh);
    check("bp2_c", c_out, ec);
    $display("backpressure: h=%h c=%h", h_out, c_out);
    @(posedge clk); #1;

    // Reset while in MUL
    drive(16'h0800, 16'h0800, 16'h0800, 16'h0080, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_c = 0;
    m_sat = 1'b0;
    check("mulrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mulrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mulrst_c", c_out, 16'h0000);
    check("mulrst_h", h_out, 16'h0000);
    $display("reset in MUL: in_ready=%b c=%h", in_ready, c_out);

    // Accumulate to the top of the range
    for (int n = 1; n <= 128; n++) begin
      run_bundle(16'h0800, 16'h0800, 16'h0800, 16'h0400, n == 1, 0, h, c);
      model_step(16'h0800, 16'h0800, 16'h0800, 16'h0400, n == 1, eh, ec);
      check($sformatf("acc%0d_c", n), c, ec);
      check($sformatf("acc%0d_h", n), h, eh);
      if (n == 128) begin
        check("acc128_c_final", c, SAT ? 16'h7FFF : 16'h8000);
        $display("acc bundle 128: h=%h c=%h", h, c);
      end
    end
`ifdef LSTM_CELL_SAT_EN
    check("acc_sat_flag", {31'd0, sat_flag}, 32'd1);
`endif

    // Random bundles against the model
    for (int r = 0; r < 60; r++) begin
      bit clr;
      int stall;
      if ($urandom_range(0, 1) == 0) begin
        ri = 16'($urandom); rf = 16'($urandom); ro = 16'($urandom); rg = 16'($urandom);
      end else begin
        ri = 16'($urandom_range(0, 3072) - 1536);
        rf = 16'($urandom_range(0, 3072) - 1536);
        ro = 16'($urandom_range(0, 3072) - 1536);
        rg = 16'($urandom_range(0, 768) - 384);
      end
      clr   = ($urandom_range(0, 9) == 0);
      stall = $urandom_range(0, 3);
      model_step(ri, rf, ro, rg, clr, eh, ec);
      run_bundle(ri, rf, ro, rg, clr, stall, h, c);
      check($sformatf("rnd%0d_h", r), h, eh);
      check($sformatf("rnd%0d_c", r), c, ec);
      $display("rnd %0d: i=%h f=%h o=%h g=%h clr=%0d -> h=%h c=%h", r, ri, rf, ro, rg, clr, h, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
